// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store controller with a fixed access
// latency in front of a word-addressed array M. Requests and responses each
// use a val/rdy handshake, and only one request is in flight at a time.
module dmem_ctrl #(
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Storage array; contents are intentionally not reset.
  logic [DATA_W-1:0] M [NUM_WORDS];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              type_q, type_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_rdy_q, req_rdy_d;
  logic              resp_val_q, resp_val_d;

  logic              access_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  addr_idx_c;
  logic              addr_err_c;
  logic              addr_lsb_unused_c;

  // Word index and out-of-range detection from the byte address.
  assign addr_idx_c        = req_addr[IDX_W+1:2];
  assign addr_err_c        = |req_addr[DATA_W-1:IDX_W+2];
  assign addr_lsb_unused_c = ^req_addr[1:0];

  // Only in-range stores touch the array, on the access edge.
  assign mem_we_c = access_c & type_q & ~perr_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    perr_d   = perr_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    access_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_val) begin
          type_d  = req_type;
          idx_d   = addr_idx_c;
          wdata_d = req_wdata;
          perr_d  = addr_err_c;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          err_d    = perr_q;
          if (perr_q || type_q) begin
            rdata_d = '0;
          end else begin
            rdata_d = M[idx_q];
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_rdy_d  = (state_d == ST_IDLE);
    resp_val_d = (state_d == ST_RESP);
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      type_q     <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      perr_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      req_rdy_q  <= 1'b1;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      perr_q     <= perr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      req_rdy_q  <= req_rdy_d;
      resp_val_q <= resp_val_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      M[idx_q] <= wdata_q;
    end
  end

  assign req_rdy    = req_rdy_q;
  assign resp_val   = resp_val_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a transaction-level model predicts handshake
// timing and response data every cycle, and literal checks pin the scenarios.
module tb_dmem_ctrl;

  localparam int unsigned LAT = 2;
  localparam int unsigned NW  = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        req_type = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Latency-sweep instances share request fields.
  logic        l_req_val = 1'b0;
  logic        l1_req_rdy, l1_resp_val, l1_resp_err;
  logic [31:0] l1_resp_rdata;
  logic        l15_req_rdy, l15_resp_val, l15_resp_err;
  logic [31:0] l15_resp_rdata;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_ctrl #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_ctrl #(.NUM_WORDS(NW), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req_val(l_req_val), .req_rdy(l1_req_rdy), .req_type(1'b1),
    .req_addr(32'h0), .req_wdata(32'h0),
    .resp_val(l1_resp_val), .resp_rdy(1'b1),
    .resp_rdata(l1_resp_rdata), .resp_err(l1_resp_err)
  );

  dmem_ctrl #(.NUM_WORDS(NW), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst),
    .req_val(l_req_val), .req_rdy(l15_req_rdy), .req_type(1'b1),
    .req_addr(32'h0), .req_wdata(32'h0),
    .resp_val(l15_resp_val), .resp_rdy(1'b1),
    .resp_rdata(l15_resp_rdata), .resp_err(l15_resp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: one request in flight, response due LAT+1 cycles
  // after acceptance, memory effect applied when the access is due.
  logic [31:0] model_mem [NW];
  logic        m_pending = 1'b0;
  int          m_age = 0;
  logic        m_type;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_err = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pending = 1'b0;
      m_age     = 0;
    end else if (!m_pending) begin
      if (req_val) begin
        m_pending = 1'b1;
        m_age     = 1;
        m_type    = req_type;
        m_addr    = req_addr;
        m_wdata   = req_wdata;
      end
    end else if (m_age > int'(LAT)) begin
      if (resp_rdy) m_pending = 1'b0;
    end else begin
      if (m_age == int'(LAT)) begin
        if (m_addr >= NW * 4) begin
          m_rdata = 32'h0;
          m_err   = 1'b1;
        end else begin
          m_err = 1'b0;
          if (m_type) begin
            model_mem[m_addr[9:2]] = m_wdata;
            m_rdata = 32'h0;
          end else begin
            m_rdata = model_mem[m_addr[9:2]];
          end
        end
      end
      m_age++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("rst_resp_val", 32'(resp_val), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'd0);
    end else begin
      chk("req_rdy", 32'(req_rdy), 32'(!m_pending));
      chk("resp_val", 32'(resp_val), 32'(m_pending && (m_age > int'(LAT))));
      if (m_pending && (m_age > int'(LAT))) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err", 32'(resp_err), 32'(m_err));
      end
    end
  end

  // Issue one request; hold>0 stalls the response for that many cycles.
  task automatic do_req(input logic t, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic er,
                        output int lat);
    int t0;
    int n;
    rd  = '0;
    er  = 1'b0;
    lat = -1;
    @(negedge clk);
    n = 0;
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      chk("req_rdy_timeout", 32'd0, 32'd1);
      return;
    end
    req_val   = 1'b1;
    req_type  = t;
    req_addr  = a;
    req_wdata = wd;
    if (hold > 0) resp_rdy = 1'b0;
    t0 = cyc;
    @(negedge clk);
    req_val = 1'b0;
    n = 0;
    while (!resp_val && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!resp_val) begin
      chk("resp_val_timeout", 32'd0, 32'd1);
      resp_rdy = 1'b1;
      return;
    end
    lat = cyc - t0;
    rd  = resp_rdata;
    er  = resp_err;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_rdata_stable", resp_rdata, rd);
        chk("bp_err_stable", 32'(resp_err), 32'(er));
        chk("bp_req_rdy_low", 32'(req_rdy), 32'd0);
        chk("bp_resp_val_high", 32'(resp_val), 32'd1);
        if (i == 1) begin
          req_val  = 1'b1;
          req_type = 1'b1;
          req_addr = 32'h20;
          req_wdata = 32'h0BAD_0BAD;
        end else begin
          req_val = 1'b0;
        end
      end
      req_val  = 1'b0;
      resp_rdy = 1'b1;
      @(negedge clk);
      chk("bp_idle_next", 32'(req_rdy), 32'd1);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          f1, f15;
  int          t0;

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;

    // Preload M[4] and do the basic read with timing.
    do_req(1'b1, 32'h10, 32'h0000_2000, 0, rd, er, lat);
    do_req(1'b0, 32'h10, 32'h0, 0, rd, er, lat);
    chk("basic_rdata", rd, 32'h0000_2000);
    chk("basic_err", 32'(er), 32'd0);
    chk("basic_latency", 32'(lat), 32'd3);
    @(negedge clk);
    chk("basic_rdy_cycle4", 32'(req_rdy), 32'd1);

    // Write then read.
    do_req(1'b1, 32'h20, 32'hDEAD_BEEF, 0, rd, er, lat);
    chk("wr_rdata_zero", rd, 32'h0);
    chk("wr_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("raw_rdata", rd, 32'hDEAD_BEEF);
    chk("mem8", dut.M[8], 32'hDEAD_BEEF);

    // Unaligned and out-of-range.
    do_req(1'b1, 32'h10, 32'h1234_5678, 0, rd, er, lat);
    do_req(1'b0, 32'h13, 32'h0, 0, rd, er, lat);
    chk("unaligned_rdata", rd, 32'h1234_5678);
    chk("unaligned_err", 32'(er), 32'd0);
    do_req(1'b1, 32'h0, 32'h1111_1111, 0, rd, er, lat);
    do_req(1'b0, 32'h400, 32'h0, 0, rd, er, lat);
    chk("oor_rd_rdata", rd, 32'h0);
    chk("oor_rd_err", 32'(er), 32'd1);
    do_req(1'b1, 32'h400, 32'h2222_2222, 0, rd, er, lat);
    chk("oor_wr_rdata", rd, 32'h0);
    chk("oor_wr_err", 32'(er), 32'd1);
    chk("oor_wr_mem0", dut.M[0], 32'h1111_1111);

    // Backpressure: response held for 5 cycles, stray request ignored.
    do_req(1'b0, 32'h20, 32'h0, 5, rd, er, lat);
    chk("bp_rdata", rd, 32'hDEAD_BEEF);
    do_req(1'b0, 32'h20, 32'h0, 0, rd, er, lat);
    chk("bp_no_stray_write", rd, 32'hDEAD_BEEF);

    // Reset while a write is waiting.
    do_req(1'b1, 32'h30, 32'h0, 0, rd, er, lat);
    @(negedge clk);
    req_val   = 1'b1;
    req_type  = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req_val = 1'b0;
    chk("wait_rdy_low", 32'(req_rdy), 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("rstw_req_rdy", 32'(req_rdy), 32'd1);
    chk("rstw_resp_val", 32'(resp_val), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstw_mem12", dut.M[12], 32'h0);
    chk("rstw_no_resp", 32'(resp_val), 32'd0);

    // Highest in-range word.
    do_req(1'b1, 32'h3FC, 32'hA5A5_5A5A, 0, rd, er, lat);
    do_req(1'b0, 32'h3FC, 32'h0, 0, rd, er, lat);
    chk("maxidx_rdata", rd, 32'hA5A5_5A5A);
    chk("maxidx_err", 32'(er), 32'd0);
    chk("maxidx_mem", dut.M[255], 32'hA5A5_5A5A);

    // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
    @(negedge clk);
    f1  = -1;
    f15 = -1;
    l_req_val = 1'b1;
    t0 = cyc;
    @(negedge clk);
    l_req_val = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (l1_resp_val && f1 < 0) f1 = cyc - t0;
      if (l15_resp_val && f15 < 0) f15 = cyc - t0;
      @(negedge clk);
    end
    chk("lat1_first_resp", 32'(f1), 32'd2);
    chk("lat15_first_resp", 32'(f15), 32'd16);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
